// File: rtl/addr_counter.sv
// Modulo-MOD up/down address counter with parallel load, terminal-count and sticky overflow.
// Compile-time option: define ADDR_CNT_SAT_EN to saturate at the terminal values instead of wrapping.
module addr_counter #(
    parameter int unsigned     WIDTH     = 6,
    parameter longint unsigned MOD       = 64,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] add,
    output logic             tc,
    output logic             ovf
);

`ifdef ADDR_CNT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

    logic [WIDTH-1:0] add_q, add_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] inc_val, dec_val, load_clamped;

    // Widen before comparing so MOD = 2^WIDTH never truncates to zero.
    assign load_clamped = (64'(load_val) >= MOD) ? MAX_VAL : load_val;

    always_comb begin
        at_max  = (add_q == MAX_VAL);
        at_zero = (add_q == '0);
        tc      = en & ~load & ((up & at_max) | (~up & at_zero));

        inc_val = add_q + ONE_VAL;
        if (at_max) begin
            inc_val = SAT_EN ? MAX_VAL : '0;
        end
        dec_val = add_q - ONE_VAL;
        if (at_zero) begin
            dec_val = SAT_EN ? '0 : MAX_VAL;
        end

        add_d = add_q;
        ovf_d = ovf_q;
        if (load) begin
            add_d = load_clamped;
            ovf_d = 1'b0;
        end else if (en) begin
            add_d = up ? inc_val : dec_val;
            if (tc) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_q <= RST_VAL;
            ovf_q <= 1'b0;
        end else begin
            add_q <= add_d;
            ovf_q <= ovf_d;
        end
    end

    assign add = add_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_addr_counter.sv
// Self-checking bench for addr_counter: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus literal scenario checks.
module tb_addr_counter;

`ifdef ADDR_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [5:0] load_val;

    logic [5:0] add64, add40;
    logic [2:0] add5;
    logic       tc64, tc40, tc5, ovf64, ovf40, ovf5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    addr_counter #(.WIDTH(6), .MOD(64), .RESET_VAL(0)) u64 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .add(add64), .tc(tc64), .ovf(ovf64));

    addr_counter #(.WIDTH(6), .MOD(40), .RESET_VAL(0)) u40 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .add(add40), .tc(tc40), .ovf(ovf40));

    addr_counter #(.WIDTH(3), .MOD(5), .RESET_VAL(3)) u5 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .add(add5), .tc(tc5), .ovf(ovf5));

    // Reference model: one entry per instance
    int mod_c[3] = '{64, 40, 5};
    int rv_c[3]  = '{0, 0, 3};
    int exp_add[3];
    bit exp_ovf[3];
    bit valid[3] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic int step_val(input int a, input int m, input bit u);
        if (u) return (a == m - 1) ? (SAT ? a : 0) : a + 1;
        else   return (a == 0) ? (SAT ? 0 : m - 1) : a - 1;
    endfunction

    function automatic bit model_tc(input int k);
        return en && !load && ((up && exp_add[k] == mod_c[k] - 1) || (!up && exp_add[k] == 0));
    endfunction

    function automatic int act_add(input int k);
        case (k)
            0:       return int'(add64);
            1:       return int'(add40);
            default: return int'(add5);
        endcase
    endfunction

    function automatic logic act_tc(input int k);
        case (k)
            0:       return tc64;
            1:       return tc40;
            default: return tc5;
        endcase
    endfunction

    function automatic logic act_ovf(input int k);
        case (k)
            0:       return ovf64;
            1:       return ovf40;
            default: return ovf5;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int lv;
            lv = (k == 2) ? int'(load_val[2:0]) : int'(load_val);
            if (reset) begin
                exp_add[k] <= rv_c[k];
                exp_ovf[k] <= 1'b0;
                valid[k]   <= 1'b1;
            end else if (load) begin
                exp_add[k] <= (lv >= mod_c[k]) ? mod_c[k] - 1 : lv;
                exp_ovf[k] <= 1'b0;
                valid[k]   <= 1'b1;
            end else if (en) begin
                if (model_tc(k)) exp_ovf[k] <= 1'b1;
                exp_add[k] <= step_val(exp_add[k], mod_c[k], up);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid[k]) begin
                check($sformatf("model_add[%0d]", k), 64'(act_add(k)), 64'(exp_add[k]));
                check($sformatf("model_tc[%0d]", k), 64'(act_tc(k)), 64'(model_tc(k)));
                check($sformatf("model_ovf[%0d]", k), 64'(act_ovf(k)), 64'(exp_ovf[k]));
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [5:0] lv);
        reset = r; en = e; up = u; load = l; load_val = lv;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        tick();
        check("rst_add64", 64'(add64), 64'd0);
        check("rst_add5", 64'(add5), 64'd3);
        check("rst_ovf40", 64'(ovf40), 64'd0);

        // Count up through the full 64-state range
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
            if (i == 0) check("s1_start", 64'(add64), 64'd0);
            if (i == 63) begin
                check("s1_add63", 64'(add64), 64'd63);
                check("s1_tc63", 64'(tc64), 64'd1);
            end else begin
                check("s1_tc_low", 64'(tc64), 64'd0);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        check("s1_wrap", 64'(add64), SAT ? 64'd63 : 64'd0);
        check("s1_ovf", 64'(ovf64), 64'd1);
        tick();

        // Count down from zero on MOD=40
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("s2_add0", 64'(add40), 64'd0);
        check("s2_tc0", 64'(tc40), 64'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("s2_add39", 64'(add40), SAT ? 64'd0 : 64'd39);
        check("s2_tc39", 64'(tc40), SAT ? 64'd1 : 64'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        check("s2_add38", 64'(add40), SAT ? 64'd0 : 64'd38);
        check("s2_ovf", 64'(ovf40), 64'd1);
        tick();

        // Load clamp with en high
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd50);
        check("s3_tc_load", 64'(tc40), 64'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        check("s3_clamp", 64'(add40), 64'd39);
        check("s3_ovf", 64'(ovf40), 64'd0);
        check("s3_noclamp64", 64'(add64), 64'd50);
        tick();

        // Reset overrides load mid-count
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd10);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        check("s4_add10", 64'(add64), 64'd10);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd20);
        check("s4_add11", 64'(add64), 64'd11);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        check("s4_rst_add", 64'(add64), 64'd0);
        check("s4_rst_ovf", 64'(ovf64), 64'd0);
        check("s4_rst_add5", 64'(add5), 64'd3);
        tick();

        // Enable toggling 1,0,1 from 5
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd5);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        check("s5_add6a", 64'(add64), 64'd6);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        check("s5_add6b", 64'(add64), 64'd6);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        check("s5_add7", 64'(add64), 64'd7);
        tick();

        // Count up past the top for three cycles
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd63);
        tick();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
            check("s6_tc", 64'(tc64), (SAT || j == 0) ? 64'd1 : 64'd0);
            check("s6_add", 64'(add64), SAT ? 64'd63 : (j == 0 ? 64'd63 : 64'(j - 1)));
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        check("s6_add_end", 64'(add64), SAT ? 64'd63 : 64'd2);
        check("s6_ovf", 64'(ovf64), 64'd1);
        tick();

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 7) == 0), 6'($urandom));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_counter.md
ADDR_COUNTER -- requirements
Module: addr_counter

Interface
REQ-001 Parameter WIDTH, default 6, count and address width in bits; legal range 1..32.
REQ-002 Parameter MOD, default 64, count modulus; legal range 2..2^WIDTH; the count sequence is 0..MOD-1.
REQ-003 Parameter RESET_VAL, default 0, value loaded by reset; legal range 0..MOD-1.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port en, input, 1 bit: count enable; one step per clk edge while high.
REQ-007 Port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 Port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 Port load_val, input, WIDTH bits: value captured when load=1.
REQ-010 Port add, output, WIDTH bits: registered current count.
REQ-011 Port tc, output, 1 bit: combinational terminal-count indication.
REQ-012 Port ovf, output, 1 bit: registered sticky wrap/overflow flag.

Function
REQ-013 Update priority at each rising clk edge SHALL be: reset, then load, then en, then hold.
REQ-014 If load=1, add SHALL take load_val next cycle; if load_val >= MOD, add SHALL take MOD-1 (clamp).
REQ-015 If load=0, en=1 and up=1: add SHALL become add+1, or 0 when add = MOD-1 (wrap).
REQ-016 If load=0, en=1 and up=0: add SHALL become add-1, or MOD-1 when add = 0 (wrap).
REQ-017 If load=0 and en=0, add and ovf SHALL hold.
REQ-018 tc SHALL equal en AND NOT load AND ((up AND add = MOD-1) OR (NOT up AND add = 0)); no register, zero latency.
REQ-019 ovf SHALL be set at the edge on which tc=1 and SHALL remain set until reset or load.
REQ-020 load SHALL clear ovf at the same edge; load with en=1 SHALL NOT step the count.
REQ-021 Direction change SHALL take effect on the same edge at which up is sampled; no pipeline delay.
REQ-022 add SHALL never hold a value >= MOD after the first reset or load.
REQ-023 Counting SHALL be synchronous; all flops SHALL share clk, with no ripple or derived clocks.

Reset
REQ-024 With reset=1 at a rising clk edge, add SHALL become RESET_VAL and ovf SHALL become 0, regardless of load and en.
REQ-025 While reset=1, tc SHALL still follow REQ-018 on the current add.
REQ-026 Reset asserted mid-count SHALL take effect at the next edge, with no partial step.
REQ-027 add and ovf are undefined before the first reset edge; the system SHALL apply reset for at least one clk cycle after power-up.

Configuration
REQ-028 Macro ADDR_CNT_SAT_EN selects terminal behaviour at compile time.
REQ-029 Without ADDR_CNT_SAT_EN, the count SHALL wrap as specified in REQ-015 and REQ-016.
REQ-030 With ADDR_CNT_SAT_EN, add SHALL hold at MOD-1 when counting up and at 0 when counting down instead of wrapping, with tc and ovf still behaving per REQ-018 and REQ-019.

Verification
REQ-031 Scenario 1: WIDTH=6, MOD=64; reset, then en=1, up=1 for 64 cycles -> add runs 0..63 then 0; tc=1 only while add=63; ovf=1 afterwards.
REQ-032 Scenario 2: MOD=40; reset, then en=1, up=0 -> add goes 0 to 39 to 38; tc=1 in the add=0 cycle.
REQ-033 Scenario 3: MOD=40; load=1, load_val=50, en=1 -> add=39 next cycle and ovf=0.
REQ-034 Scenario 4: MOD=64; counting up at add=10, assert reset and load together -> add=0 (RESET_VAL) and ovf=0 next cycle.
REQ-035 Scenario 5: MOD=64; en toggles 1,0,1 from add=5 with up=1 -> add sequence 6, 6, 7.
REQ-036 Scenario 6: with ADDR_CNT_SAT_EN, MOD=64; count up past 63 for 3 cycles -> add stays 63, tc=1 in each cycle, ovf=1.
